// File: rtl/ch_sched_pkg.sv
// ---------------------------------------------------------------------------
// ch_sched_pkg
//   Shared types and constants for the channel priority scheduler.
//   - state_t  : scheduler FSM state encoding
//   - MODE_*   : selection mode encodings carried on rr_mode_i
// ---------------------------------------------------------------------------
package ch_sched_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    SERVING = 2'd2
  } state_t;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

endpackage : ch_sched_pkg

// File: rtl/ch_rr_pick.sv
// ---------------------------------------------------------------------------
// ch_rr_pick
//   Combinational channel picker.
//   Fixed mode : lowest set index of pend.
//   RR mode    : first set index at or after start, wrapping N_CH-1 -> 0.
//   Ports:
//     pend   in  N_CH   candidate set
//     start  in  IDX_W  round-robin start pointer (ignored in fixed mode)
//     mode   in  1      MODE_FIXED / MODE_RR
//     pick   out IDX_W  selected index (valid only when any = 1)
//     any    out 1      pend has at least one bit set
// ---------------------------------------------------------------------------
module ch_rr_pick
  import ch_sched_pkg::*;
#(
  parameter  int N_CH  = 16,
  localparam int IDX_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0]  pend,
  input  logic [IDX_W-1:0] start,
  input  logic             mode,
  output logic [IDX_W-1:0] pick,
  output logic             any
);

  localparam int PW = $clog2(2 * N_CH);

  logic [N_CH-1:0]   mask;
  logic [2*N_CH-1:0] dbl;
  logic [PW-1:0]     pos;

  // Lower half holds only bits at/after start; upper half is the full set,
  // so scanning the concatenation from bit 0 upward yields the wrapped
  // search without needing N_CH to be a power of two.
  always_comb begin
    mask = '0;
    for (int i = 0; i < N_CH; i++)
      mask[i] = (mode == MODE_FIXED) || (i >= int'(start));
    dbl = {pend, pend & mask};
    pos = '0;
    for (int i = 2*N_CH-1; i >= 0; i--)
      if (dbl[i]) pos = PW'(i);
    if (pos >= PW'(N_CH)) pick = IDX_W'(pos - PW'(N_CH));
    else                  pick = IDX_W'(pos);
    any = |pend;
  end

endmodule : ch_rr_pick

// File: rtl/ch_priority_sched.sv
// ---------------------------------------------------------------------------
// ch_priority_sched
//   Captures a set of requesting channels on arm, then grants one pending
//   channel per dump strobe (fixed priority or round-robin). Closes the
//   cycle with a one-cycle cycle_done_o pulse once the set is exhausted.
//   Ports:
//     clk_i, resetn_i       clock, async active-low reset
//     ch_sel_i   in  N_CH   request vector, sampled on arm_i
//     arm_i      in  1      capture (IDLE) or merge (ARMED/SERVING)
//     dump_i     in  1      grant next pending channel or close the cycle
//     abort_i    in  1      drop pending set, back to IDLE, no done pulse
//     rr_mode_i  in  1      0 fixed priority, 1 round-robin
//     ch_sel_o   out N_CH   one-hot grant
//     ch_idx_o   out IDX_W  binary grant index
//     ch_valid_o out 1      grant live
//     pending_o  out N_CH   pending set
//     idle_o     out 1      FSM in IDLE
//     cycle_done_o out 1    cycle completed normally (one cycle)
//   Event priority: abort_i > dump_i > arm_i.
// ---------------------------------------------------------------------------
module ch_priority_sched
  import ch_sched_pkg::*;
#(
  parameter  int N_CH  = 16,
  localparam int IDX_W = $clog2(N_CH)
) (
  input  logic             clk_i,
  input  logic             resetn_i,
  input  logic [N_CH-1:0]  ch_sel_i,
  input  logic             arm_i,
  input  logic             dump_i,
  input  logic             abort_i,
  input  logic             rr_mode_i,
  output logic [N_CH-1:0]  ch_sel_o,
  output logic [IDX_W-1:0] ch_idx_o,
  output logic             ch_valid_o,
  output logic [N_CH-1:0]  pending_o,
  output logic             idle_o,
  output logic             cycle_done_o
);

  state_t           state;
  logic [IDX_W-1:0] rr_ptr;

  logic [IDX_W-1:0] pick;
  logic             any;
  logic [N_CH-1:0]  pick_oh;
  logic [N_CH-1:0]  pend_nxt;
  logic [IDX_W-1:0] rr_nxt;

  ch_rr_pick #(.N_CH(N_CH)) u_pick (
    .pend  (pending_o),
    .start (rr_ptr),
    .mode  (rr_mode_i),
    .pick  (pick),
    .any   (any)
  );

  // Grant is chosen from the pre-merge set; the merge is applied after the
  // granted bit is cleared so a re-requested granted channel stays pending.
  always_comb begin
    pick_oh = '0;
    for (int i = 0; i < N_CH; i++)
      pick_oh[i] = (pick == IDX_W'(i));
    pend_nxt = (pending_o & ~pick_oh) | (arm_i ? ch_sel_i : '0);
    // Compare-based wrap: N_CH need not be a power of two.
    rr_nxt   = (pick == IDX_W'(N_CH-1)) ? '0 : pick + IDX_W'(1);
  end

  assign idle_o = (state == IDLE);

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state        <= IDLE;
      pending_o    <= '0;
      rr_ptr       <= '0;
      ch_sel_o     <= '0;
      ch_idx_o     <= '0;
      ch_valid_o   <= 1'b0;
      cycle_done_o <= 1'b0;
    end else begin
      cycle_done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (arm_i) begin
            pending_o <= ch_sel_i;
            // Empty request closes the cycle immediately.
            if (ch_sel_i == '0) cycle_done_o <= 1'b1;
            else                state        <= ARMED;
          end
        end
        ARMED, SERVING: begin
          if (abort_i) begin
            state      <= IDLE;
            pending_o  <= '0;
            ch_sel_o   <= '0;
            ch_idx_o   <= '0;
            ch_valid_o <= 1'b0;
          end else if (dump_i) begin
            if (any) begin
              state      <= SERVING;
              pending_o  <= pend_nxt;
              ch_sel_o   <= pick_oh;
              ch_idx_o   <= pick;
              ch_valid_o <= 1'b1;
              rr_ptr     <= rr_nxt;
            end else begin
              state        <= IDLE;
              ch_sel_o     <= '0;
              ch_idx_o     <= '0;
              ch_valid_o   <= 1'b0;
              cycle_done_o <= 1'b1;
            end
          end else if (arm_i) begin
            pending_o <= pending_o | ch_sel_i;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule : ch_priority_sched

// File: tb/tb_ch_priority_sched.sv
// Scoreboard bench: stimulus pushes expected grant/done events, per-DUT
// monitors pop and compare whenever the DUT presents a new event.
module tb_ch_priority_sched;

  typedef struct {
    bit          done;
    int          idx;
    logic [15:0] pend;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // DUT A: 16 channels
  logic [15:0] a_sel_i;
  logic        a_arm, a_dump, a_abort, a_rr;
  logic [15:0] a_sel, a_pend;
  logic [3:0]  a_idx;
  logic        a_valid, a_idle, a_done;

  // DUT B: 5 channels
  logic [4:0]  b_sel_i;
  logic        b_arm, b_dump, b_abort, b_rr;
  logic [4:0]  b_sel, b_pend;
  logic [2:0]  b_idx;
  logic        b_valid, b_idle, b_done;

  ch_priority_sched #(.N_CH(16)) dut_a (
    .clk_i(clk), .resetn_i(rst_n), .ch_sel_i(a_sel_i), .arm_i(a_arm),
    .dump_i(a_dump), .abort_i(a_abort), .rr_mode_i(a_rr),
    .ch_sel_o(a_sel), .ch_idx_o(a_idx), .ch_valid_o(a_valid),
    .pending_o(a_pend), .idle_o(a_idle), .cycle_done_o(a_done)
  );

  ch_priority_sched #(.N_CH(5)) dut_b (
    .clk_i(clk), .resetn_i(rst_n), .ch_sel_i(b_sel_i), .arm_i(b_arm),
    .dump_i(b_dump), .abort_i(b_abort), .rr_mode_i(b_rr),
    .ch_sel_o(b_sel), .ch_idx_o(b_idx), .ch_valid_o(b_valid),
    .pending_o(b_pend), .idle_o(b_idle), .cycle_done_o(b_done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic g(input bit b, input int idx, input logic [15:0] pend);
    exp_t e;
    e.done = 1'b0; e.idx = idx; e.pend = pend;
    if (b) qb.push_back(e); else qa.push_back(e);
  endtask

  task automatic dn(input bit b);
    exp_t e;
    e.done = 1'b1; e.idx = 0; e.pend = '0;
    if (b) qb.push_back(e); else qa.push_back(e);
  endtask

  // Drive one strobe cycle; called and returns on a negedge.
  task automatic st(input bit b, input bit arm, input bit dump, input bit abort,
                    input logic [15:0] sel);
    if (!b) begin a_arm = arm; a_dump = dump; a_abort = abort; a_sel_i = sel; end
    else    begin b_arm = arm; b_dump = dump; b_abort = abort; b_sel_i = sel[4:0]; end
    @(negedge clk);
    a_arm = 0; a_dump = 0; a_abort = 0; a_sel_i = '0;
    b_arm = 0; b_dump = 0; b_abort = 0; b_sel_i = '0;
  endtask

  // An event is a done pulse, or a grant whose sel/pending differs from
  // the previous sample (covers grants, re-grants, and merges while serving).
  logic [15:0] pa_sel, pa_pend;
  logic        pa_v = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (a_done || (a_valid && (!pa_v || a_sel != pa_sel || a_pend != pa_pend))) begin
      if (qa.size() == 0) chk("A spurious event", qa.size(), 1);
      else begin
        e = qa.pop_front();
        if (e.done) begin
          chk("A done pulse", 32'(a_done), 1);
          chk("A done valid", 32'(a_valid), 0);
          chk("A done idle", 32'(a_idle), 1);
        end else begin
          chk("A grant idx", 32'(a_idx), e.idx);
          chk("A grant sel", 32'(a_sel), 32'(1) << e.idx);
          chk("A grant pend", 32'(a_pend), 32'(e.pend));
          chk("A grant done", 32'(a_done), 0);
        end
      end
    end
    pa_v = a_valid; pa_sel = a_sel; pa_pend = a_pend;
  end

  logic [4:0] pb_sel, pb_pend;
  logic       pb_v = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (b_done || (b_valid && (!pb_v || b_sel != pb_sel || b_pend != pb_pend))) begin
      if (qb.size() == 0) chk("B spurious event", qb.size(), 1);
      else begin
        e = qb.pop_front();
        if (e.done) begin
          chk("B done pulse", 32'(b_done), 1);
          chk("B done valid", 32'(b_valid), 0);
          chk("B done idle", 32'(b_idle), 1);
        end else begin
          chk("B grant idx", 32'(b_idx), e.idx);
          chk("B grant sel", 32'(b_sel), 32'(1) << e.idx);
          chk("B grant pend", 32'(b_pend), 32'(e.pend));
        end
      end
    end
    pb_v = b_valid; pb_sel = b_sel; pb_pend = b_pend;
  end

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    a_sel_i = '0; a_arm = 0; a_dump = 0; a_abort = 0; a_rr = 0;
    b_sel_i = '0; b_arm = 0; b_dump = 0; b_abort = 0; b_rr = 1;
    do_reset();
    chk("reset sel", 32'(a_sel), 0);
    chk("reset idx", 32'(a_idx), 0);
    chk("reset valid", 32'(a_valid), 0);
    chk("reset pend", 32'(a_pend), 0);
    chk("reset idle", 32'(a_idle), 1);
    chk("reset done", 32'(a_done), 0);

    // 1: fixed mode, 0x0025 -> 0, 2, 5, then close
    st(0, 1, 0, 0, 16'h0025);
    chk("t1 armed pend", 32'(a_pend), 32'h25);
    chk("t1 armed idle", 32'(a_idle), 0);
    g(0, 0, 16'h0024); st(0, 0, 1, 0, '0);
    g(0, 2, 16'h0020); st(0, 0, 1, 0, '0);
    g(0, 5, 16'h0000); st(0, 0, 1, 0, '0);
    dn(0);             st(0, 0, 1, 0, '0);
    st(0, 0, 0, 0, '0);
    chk("t1 done width", 32'(a_done), 0);

    // 2: round-robin with wrap and abort keeping rr_ptr
    do_reset(); a_rr = 1;
    st(0, 1, 0, 0, 16'h8001);
    g(0, 0, 16'h8000); st(0, 0, 1, 0, '0);
    g(0, 15, 16'h0000); st(0, 0, 1, 0, '0);
    dn(0);             st(0, 0, 1, 0, '0);
    st(0, 1, 0, 0, 16'h0003);
    g(0, 0, 16'h0002); st(0, 0, 1, 0, '0);
    st(0, 0, 0, 1, '0);
    st(0, 1, 0, 0, 16'h0003);
    g(0, 1, 16'h0001); st(0, 0, 1, 0, '0);
    g(0, 0, 16'h0000); st(0, 0, 1, 0, '0);
    dn(0);             st(0, 0, 1, 0, '0);

    // 3: merge with simultaneous dump, re-request of granted channel
    do_reset(); a_rr = 0;
    st(0, 1, 0, 0, 16'h0006);
    g(0, 1, 16'h0004); st(0, 0, 1, 0, '0);
    g(0, 2, 16'h0003); st(0, 1, 1, 0, 16'h0003);
    g(0, 0, 16'h0002); st(0, 0, 1, 0, '0);
    g(0, 1, 16'h0000); st(0, 0, 1, 0, '0);
    dn(0);             st(0, 0, 1, 0, '0);
    st(0, 1, 0, 0, 16'h0018);
    g(0, 3, 16'h0018); st(0, 1, 1, 0, 16'h0008);
    g(0, 3, 16'h0010); st(0, 0, 1, 0, '0);
    g(0, 4, 16'h0000); st(0, 0, 1, 0, '0);
    g(0, 4, 16'h0001); st(0, 1, 0, 0, 16'h0001);
    g(0, 0, 16'h0000); st(0, 0, 1, 0, '0);
    dn(0);             st(0, 0, 1, 0, '0);

    // 4: abort mid-serve, dump in IDLE ignored
    st(0, 1, 0, 0, 16'h00F0);
    g(0, 4, 16'h00E0); st(0, 0, 1, 0, '0);
    st(0, 0, 0, 1, '0);
    chk("t4 abort pend", 32'(a_pend), 0);
    chk("t4 abort valid", 32'(a_valid), 0);
    chk("t4 abort idle", 32'(a_idle), 1);
    chk("t4 abort done", 32'(a_done), 0);
    st(0, 0, 1, 0, '0);
    chk("t4 idle dump valid", 32'(a_valid), 0);
    chk("t4 idle dump idle", 32'(a_idle), 1);

    // 5: empty arm closes immediately
    dn(0); st(0, 1, 0, 0, 16'h0000);
    chk("t5 idle", 32'(a_idle), 1);
    st(0, 0, 0, 0, '0);
    chk("t5 done width", 32'(a_done), 0);

    // 6a: asynchronous reset while serving
    st(0, 1, 0, 0, 16'h0003);
    g(0, 0, 16'h0002); st(0, 0, 1, 0, '0);
    @(posedge clk); #3 rst_n = 1'b0; #1;
    chk("t6 async sel", 32'(a_sel), 0);
    chk("t6 async idx", 32'(a_idx), 0);
    chk("t6 async valid", 32'(a_valid), 0);
    chk("t6 async pend", 32'(a_pend), 0);
    chk("t6 async idle", 32'(a_idle), 1);
    @(negedge clk); rst_n = 1'b1;

    // 6b: N_CH = 5 round-robin, wrap at 4 -> 0
    st(1, 1, 0, 0, 16'h0011);
    g(1, 0, 16'h0010); st(1, 0, 1, 0, '0);
    g(1, 4, 16'h0000); st(1, 0, 1, 0, '0);
    dn(1);             st(1, 0, 1, 0, '0);
    st(1, 1, 0, 0, 16'h0006);
    g(1, 1, 16'h0004); st(1, 0, 1, 0, '0);
    g(1, 2, 16'h0000); st(1, 0, 1, 0, '0);
    dn(1);             st(1, 0, 1, 0, '0);
    st(1, 1, 0, 0, 16'h0011);
    g(1, 4, 16'h0001); st(1, 0, 1, 0, '0);
    g(1, 0, 16'h0000); st(1, 0, 1, 0, '0);
    dn(1);             st(1, 0, 1, 0, '0);

    st(0, 0, 0, 0, '0);
    chk("A queue drained", qa.size(), 0);
    chk("B queue drained", qb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_ch_priority_sched

// File: doc/ch_priority_sched.md
Name: ch_priority_sched

Overview:
Parametrised, fully synchronous successor to the channel priority FSM. It captures a set of requesting channels on arm, then on each dump strobe grants exactly one pending channel, either lowest-index-first or round-robin. It signals end-of-cycle when the pending set is exhausted and supports merging new requests mid-cycle and aborting a cycle. It sits between the channel trigger front-end and the serial encoder/dump path.

Parameters:
N_CH, 16, number of channels; any value >= 2, not restricted to powers of two.
IDX_W, $clog2(N_CH), channel index width; derived, not overridden.

Ports:
clk_i  in  1  system clock, rising edge.
resetn_i  in  1  asynchronous active-low reset.
ch_sel_i  in  N_CH  request vector, sampled on arm_i.
arm_i  in  1  single-cycle strobe: capture or merge ch_sel_i into the pending set.
dump_i  in  1  single-cycle strobe: grant next pending channel or close the cycle.
abort_i  in  1  single-cycle strobe: discard the pending set, return to IDLE.
rr_mode_i  in  1  0 = fixed priority (index 0 highest); 1 = round-robin; sampled at each grant.
ch_sel_o  out  N_CH  one-hot granted channel, registered.
ch_idx_o  out  IDX_W  binary index of the granted channel.
ch_valid_o  out  1  ch_sel_o/ch_idx_o hold a live grant.
pending_o  out  N_CH  current pending set.
idle_o  out  1  FSM in IDLE.
cycle_done_o  out  1  one-cycle pulse when a cycle completes normally.

Behaviour:
- Reset (async assert, sync release): state = IDLE, pending = 0, rr_ptr = 0, ch_sel_o = 0, ch_idx_o = 0, ch_valid_o = 0, cycle_done_o = 0, idle_o = 1.
- States: IDLE, ARMED (pending captured, no grant yet), SERVING (grant held).
- Event priority within one cycle: abort_i > dump_i > arm_i. Lower-priority events in the same cycle are handled only as stated below.
- IDLE:
  - arm_i: pending <= ch_sel_i.
  - If ch_sel_i == 0: stay in IDLE and pulse cycle_done_o next cycle.
  - Otherwise go to ARMED.
  - dump_i and abort_i are ignored.
- ARMED or SERVING, on dump_i:
  - If pending != 0: pick = selected channel. pending[pick] <= 0, ch_sel_o <= onehot(pick), ch_idx_o <= pick, ch_valid_o <= 1, next state SERVING.
  - If pending == 0: clear ch_sel_o, ch_idx_o and ch_valid_o; go to IDLE; pulse cycle_done_o.
  - Grant latency: outputs update on the same rising edge that samples dump_i. A grant is held until the next dump_i or abort_i.
- Selection rules:
  - Fixed mode: pick = lowest set index of pending.
  - Round-robin mode: pick = first set index at or after rr_ptr, wrapping at N_CH-1 -> 0.
  - After every grant in either mode, rr_ptr <= (pick == N_CH-1) ? 0 : pick+1. Wrap is by compare, not modulo-2^IDX_W.
  - rr_ptr persists across cycles and is cleared only by reset.
- arm_i in ARMED or SERVING: pending <= pending | ch_sel_i (merge); state unchanged.
  - With a simultaneous dump_i, the grant is selected from the pre-merge pending set. The merge is then applied after clearing the granted bit, so a re-requested granted channel stays pending.
- abort_i in ARMED or SERVING: pending <= 0, grant outputs cleared, go to IDLE. No cycle_done_o pulse. rr_ptr is kept.
- cycle_done_o is exactly one cycle wide and never asserted on abort.
- idle_o = (state == IDLE), decoded from registered state.
- No latches and no derived clocks. All state is in one always_ff on clk_i / negedge resetn_i.

Decomposition:
- Package ch_sched_pkg:
  - state enum typedef {IDLE, ARMED, SERVING}.
  - Mode constants MODE_FIXED = 1'b0, MODE_RR = 1'b1.
- One combinational sub-module, ch_rr_pick:
  - Inputs: pending vector, start pointer, mode.
  - Outputs: pick index and any-valid flag.
  - Implemented as a double-width masked priority encode, supporting non-power-of-two N_CH.
- The top level holds the FSM, pending register, rr_ptr and output registers.

Test Plan:
1. Reset, then arm with ch_sel_i = 0x0025 in fixed mode, then 4 dumps -> grants idx 0, 2, 5. The fourth dump clears ch_valid_o, cycle_done_o pulses for 1 cycle, idle_o = 1.
2. Round-robin, N_CH = 16: cycle 1 arm 0x8001, two dumps -> idx 0, 15, then rr_ptr wraps to 0. Cycle 2 arm 0x0003, first dump -> idx 0. With rr_ptr forced to 1 via a prior grant of 0, arm 0x0003 -> idx 1 then 0.
3. Arm 0x0006, dump (grant 1), then arm 0x0003 and dump in the same cycle -> grant idx 2, pending_o = 0x0003. Next dumps grant 0 then 1.
4. Arm 0x00F0, dump, then abort_i -> pending_o = 0, ch_valid_o = 0, idle_o = 1, no cycle_done_o pulse. A following dump_i in IDLE produces no grant.
5. Arm with ch_sel_i = 0 -> stays IDLE, cycle_done_o pulses once.
6. Assert resetn_i low mid-SERVING, asynchronously off the clock edge -> all outputs return to reset values immediately. Run with N_CH = 5 and rr_mode_i = 1: arm 0x11, grants 0, 4, and rr_ptr wraps to 0.
